// File: rtl/recepcao_movimentos.sv
// UART (8N1) receiver and framed move-list parser with an indexed move buffer.
// Optional trailing XOR checksum byte: define RECEPCAO_MOVIMENTOS_CHECKSUM_EN.
module recepcao_movimentos #(
    parameter int CLK_HZ  = 50000000,
    parameter int BAUD    = 115200,
    parameter int MAX_MOV = 64,
    parameter int ADDR_W  = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              obter_movimentos,
    input  logic              rx_serial,
    input  logic [ADDR_W-1:0] endereco,
    output logic [2:0]        movimento,
    output logic [ADDR_W:0]   total_movimentos,
    output logic              movimentos_recebidos,
    output logic              erro,
    output logic [3:0]        db_estado
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] FIM_BIT  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] MEIO_BIT = CNT_W'(DIV / 2 - 1);
    localparam logic [7:0]       CABECALHO = 8'hA5;

    typedef enum logic [1:0] {
        RX_OCIOSO = 2'd0,
        RX_INICIO = 2'd1,
        RX_DADOS  = 2'd2,
        RX_PARADA = 2'd3
    } rx_estado_t;

    typedef enum logic [2:0] {
        OCIOSO     = 3'd0,
        ESPERA_CAB = 3'd1,
        ESPERA_N   = 3'd2,
        RECEBE_MOV = 3'd3,
`ifdef RECEPCAO_MOVIMENTOS_CHECKSUM_EN
        ESPERA_CHK = 3'd4,
`endif
        FIM        = 3'd5,
        ERRO       = 3'd6
    } estado_t;

    function automatic logic f_mov_valido(input logic [7:0] b);
        return (b <= 8'h05);
    endfunction

    function automatic logic f_n_valido(input logic [7:0] b);
        return (b != 8'h00) && (int'(b) <= MAX_MOV);
    endfunction

    logic             r_rx_meta;
    logic             r_rx_sync;
    logic             r_rx_prev;
    rx_estado_t       r_rx_estado;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_byte_ok;
    logic             r_byte_fe;

    estado_t          r_estado;
    logic [ADDR_W:0]  r_qtd;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]  r_total;
    logic             r_recebidos;
    logic             r_erro;
    logic [2:0]       r_movimento;
    logic [2:0]       r_mem [MAX_MOV];
    logic             w_wr;
`ifdef RECEPCAO_MOVIMENTOS_CHECKSUM_EN
    logic [7:0]       r_xor;
`endif

    // Line synchronizer; flops clear to 0 so a start bit needs the line to idle high first
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b0;
            r_rx_sync <= 1'b0;
            r_rx_prev <= 1'b0;
        end else begin
            r_rx_meta <= rx_serial;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // Bit-level receiver: start validation at mid-bit, 8 data bits LSB first, stop check
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rx_estado <= RX_OCIOSO;
            r_cnt       <= {CNT_W{1'b0}};
            r_bit       <= 3'd0;
            r_shift     <= 8'h00;
            r_byte_ok   <= 1'b0;
            r_byte_fe   <= 1'b0;
        end else begin
            r_byte_ok <= 1'b0;
            r_byte_fe <= 1'b0;
            case (r_rx_estado)
                RX_OCIOSO: begin
                    r_cnt <= {CNT_W{1'b0}};
                    if (r_rx_prev && !r_rx_sync) begin
                        r_rx_estado <= RX_INICIO;
                    end
                end
                RX_INICIO: begin
                    if (r_cnt == MEIO_BIT) begin
                        r_cnt       <= {CNT_W{1'b0}};
                        r_bit       <= 3'd0;
                        r_rx_estado <= r_rx_sync ? RX_OCIOSO : RX_DADOS;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RX_DADOS: begin
                    if (r_cnt == FIM_BIT) begin
                        r_cnt   <= {CNT_W{1'b0}};
                        r_shift <= {r_rx_sync, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_rx_estado <= RX_PARADA;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RX_PARADA: begin
                    if (r_cnt == FIM_BIT) begin
                        r_cnt       <= {CNT_W{1'b0}};
                        r_byte_ok   <= r_rx_sync;
                        r_byte_fe   <= ~r_rx_sync;
                        r_rx_estado <= RX_OCIOSO;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_rx_estado <= RX_OCIOSO;
            endcase
        end
    end

    // Buffer write enable: a valid move byte while collecting moves, unless re-armed this cycle
    always_comb begin
        w_wr = 1'b0;
        if ((r_estado == RECEBE_MOV) && r_byte_ok && f_mov_valido(r_shift) && !obter_movimentos) begin
            w_wr = 1'b1;
        end else begin
            w_wr = 1'b0;
        end
    end

    // Frame parser; re-arming from any state discards the partial frame
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado    <= OCIOSO;
            r_qtd       <= {(ADDR_W+1){1'b0}};
            r_ptr       <= {ADDR_W{1'b0}};
            r_total     <= {(ADDR_W+1){1'b0}};
            r_recebidos <= 1'b0;
            r_erro      <= 1'b0;
`ifdef RECEPCAO_MOVIMENTOS_CHECKSUM_EN
            r_xor       <= 8'h00;
`endif
        end else begin
            r_recebidos <= 1'b0;
            r_erro      <= 1'b0;
            if (obter_movimentos) begin
                r_estado <= ESPERA_CAB;
                if (r_estado == OCIOSO) begin
                    r_total <= {(ADDR_W+1){1'b0}};
                end
            end else begin
                case (r_estado)
                    OCIOSO: r_estado <= OCIOSO;
                    ESPERA_CAB: begin
                        if (r_byte_ok && (r_shift == CABECALHO)) begin
                            r_estado <= ESPERA_N;
                        end
                    end
                    ESPERA_N: begin
                        if (r_byte_ok && f_n_valido(r_shift)) begin
                            r_qtd    <= (ADDR_W+1)'(r_shift);
                            r_ptr    <= {ADDR_W{1'b0}};
`ifdef RECEPCAO_MOVIMENTOS_CHECKSUM_EN
                            r_xor    <= r_shift;
`endif
                            r_estado <= RECEBE_MOV;
                        end else if (r_byte_ok || r_byte_fe) begin
                            r_estado <= ERRO;
                        end
                    end
                    RECEBE_MOV: begin
                        if (r_byte_ok && f_mov_valido(r_shift)) begin
                            r_ptr <= r_ptr + ADDR_W'(1);
`ifdef RECEPCAO_MOVIMENTOS_CHECKSUM_EN
                            r_xor <= r_xor ^ r_shift;
`endif
                            if (({1'b0, r_ptr} + (ADDR_W+1)'(1)) == r_qtd) begin
`ifdef RECEPCAO_MOVIMENTOS_CHECKSUM_EN
                                r_estado <= ESPERA_CHK;
`else
                                r_estado <= FIM;
`endif
                            end
                        end else if (r_byte_ok || r_byte_fe) begin
                            r_estado <= ERRO;
                        end
                    end
`ifdef RECEPCAO_MOVIMENTOS_CHECKSUM_EN
                    ESPERA_CHK: begin
                        if (r_byte_ok) begin
                            r_estado <= (r_shift == r_xor) ? FIM : ERRO;
                        end else if (r_byte_fe) begin
                            r_estado <= ERRO;
                        end
                    end
`endif
                    FIM: begin
                        r_recebidos <= 1'b1;
                        r_total     <= r_qtd;
                        r_estado    <= OCIOSO;
                    end
                    ERRO: begin
                        r_erro   <= 1'b1;
                        r_estado <= ESPERA_CAB;
                    end
                    default: r_estado <= OCIOSO;
                endcase
            end
        end
    end

    // Move storage; contents are not reset
    always_ff @(posedge clock) begin
        if (w_wr) begin
            r_mem[r_ptr] <= r_shift[2:0];
        end
    end

    // Registered read port (read-before-write on address collision)
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_movimento <= 3'd0;
        end else begin
            r_movimento <= r_mem[endereco];
        end
    end

    assign movimento            = r_movimento;
    assign total_movimentos     = r_total;
    assign movimentos_recebidos = r_recebidos;
    assign erro                 = r_erro;
    assign db_estado            = {1'b0, r_estado};

endmodule

// File: doc/recepcao_movimentos.md
Name: recepcao_movimentos

Overview:
- Receives the solution move list from the host PC over the UART line `rx_serial`. This is the inbound direction, opposite to the color transmission that leaves on `saida_serial`.
- Deserializes 8N1 bytes and parses a framed move list. Each move is validated and stored in an internal buffer.
- Pulses `movimentos_recebidos` to the control unit when a complete frame arrives. The data path then reads moves back by index to drive the servos.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate; DIV = CLK_HZ/BAUD clocks per bit (434 at default).
- MAX_MOV, 64, buffer depth in moves.
- ADDR_W, 6, read address width; must satisfy 2^ADDR_W >= MAX_MOV.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- obter_movimentos  in  1  one-cycle pulse that arms reception of a new frame.
- rx_serial  in  1  UART line, idles high, asynchronous to clock.
- endereco  in  ADDR_W  read index into the move buffer.
- movimento  out  3  move code stored at `endereco`, registered.
- total_movimentos  out  ADDR_W+1  move count N of the last accepted frame.
- movimentos_recebidos  out  1  one-cycle pulse when a frame is accepted.
- erro  out  1  one-cycle pulse when a frame is rejected.
- db_estado  out  4  current parser state code, for the hex display.

Behaviour:
- Reset values (reset=0): all outputs 0; parser in OCIOSO; UART receiver idle; buffer contents undefined.

UART receiver:
- `rx_serial` passes through a 2-flop synchronizer before any use.
- A falling edge while the receiver is idle starts the bit counter.
- The start bit is re-sampled at DIV/2; if it reads 1, it is a glitch and the receiver returns to idle.
- 8 data bits are sampled at DIV intervals, LSB first.
- If the stop bit samples 1, a byte strobe is issued 1 cycle after the stop sample.
- If the stop bit samples 0 (framing error), the byte is dropped. The parser treats this as a bad byte when it is in any state other than OCIOSO or ESPERA_CAB.

Frame format: 0xA5, N, M0 .. M(N-1) [, CHK].
- N must satisfy 1 <= N <= MAX_MOV.
- Each Mi must be in 0x00..0x05. The move code is Mi[2:0].

Parser states (db_estado code in brackets):
- OCIOSO [0]: all bytes are ignored. `obter_movimentos` moves to ESPERA_CAB and clears `total_movimentos` to 0.
- ESPERA_CAB [1]: 0xA5 moves to ESPERA_N. Any other byte, including a framing error, is silently ignored.
- ESPERA_N [2]: a valid N is latched into a count register and the write pointer is set to 0, then RECEBE_MOV. An invalid N goes to ERRO.
- RECEBE_MOV [3]: each valid move is written to buffer[ptr] and ptr increments.
  - After the N-th move: go to ESPERA_CHK if CHECKSUM_EN is defined, otherwise FIM.
  - A byte > 0x05 or a framing error goes to ERRO.
- ESPERA_CHK [4]: defined only with CHECKSUM_EN; see Optional Feature.
- FIM [5]: for one cycle, assert `movimentos_recebidos` and load `total_movimentos` = N, then return to OCIOSO.
- ERRO [6]: for one cycle, assert `erro`, then return to ESPERA_CAB. The parser stays armed, so the host can resend without a new `obter_movimentos`.

Boundary conditions:
- `obter_movimentos` asserted in any state other than OCIOSO restarts the parser at ESPERA_CAB; the partial frame is discarded.
- Read port: `movimento` = buffer[endereco] with 1-cycle latency.
- A read with `endereco` >= `total_movimentos` returns an undefined move code; the control unit bounds its reads with `total_movimentos`.
- A simultaneous buffer write and read of the same address returns the old data.
- Reset asserted mid-byte or mid-frame aborts immediately. After release the receiver waits for `rx_serial` to idle high before detecting a start bit.

Optional Feature:
- Macro: RECEPCAO_MOVIMENTOS_CHECKSUM_EN.
- When defined:
  - A running XOR of N and every Mi is kept.
  - After the last move the parser enters ESPERA_CHK and waits for the CHK byte.
  - If CHK equals the running XOR, the parser goes to FIM.
  - On a mismatch or a framing error, the parser goes to ERRO.
- When undefined: the ESPERA_CHK state and the XOR logic are absent, and the last move goes directly to FIM.

Test Plan:
- Basic frame, no checksum: pulse `obter_movimentos`, then send A5 03 01 04 02.
  - Expect one `movimentos_recebidos` pulse and `total_movimentos` = 3.
  - Reads at `endereco` 0/1/2 return 1/4/2 one cycle later.
- Invalid move code: send A5 02 01 07.
  - Expect an `erro` pulse and `db_estado` = 1.
  - A following A5 01 05 is accepted with `total_movimentos` = 1.
- Bad N: send A5 00, then A5 41 (N = 65).
  - Expect two `erro` pulses and no `movimentos_recebidos`.
- Glitch and framing error: apply a 100-cycle low glitch on `rx_serial`, then a byte with stop bit = 0 while in ESPERA_CAB.
  - Expect no byte strobe from the glitch.
  - Expect the framing-error byte to be ignored, with no `erro` pulse.
- Restart and reset: pulse `obter_movimentos` midway through A5 04 00 01, then send A5 01 03 → accepted with `total_movimentos` = 1.
  - Assert reset mid-byte → all outputs 0, state OCIOSO.
- With CHECKSUM_EN: send A5 02 01 02 01.
  - CHK = 02^01^02 = 01, so expect accept.
  - Resending with CHK = 00 → `erro`.
